// File: rtl/acqbuf_pkg.sv
// ============================================================================
//  Module  : acqbuf_pkg
//  Brief   : State encoding and default widths for the acquisition controller.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package acqbuf_pkg;

    localparam int unsigned c_addr_width  = 12;
    localparam int unsigned c_data_width  = 64;
    localparam int unsigned c_dec_width   = 8;
    localparam int unsigned c_miss_width  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } acq_state_t;

endpackage : acqbuf_pkg

`default_nettype wire

// File: rtl/acq_decim.sv
// ============================================================================
//  Module  : acq_decim
//  Brief   : Loadable modulo-(decim+1) phase counter; keep marks phase 0.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module acq_decim #(
    parameter int unsigned DECWIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                ld,
    input  logic [DECWIDTH-1:0] decim,
    input  logic                en,
    output logic                keep
);

    logic [DECWIDTH-1:0] r_mod;
    logic [DECWIDTH-1:0] r_count;

    // A load also restarts the phase so the first kept beat is phase 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mod   <= '0;
            r_count <= '0;
        end else if (ld) begin
            r_mod   <= decim;
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == r_mod) ? '0 : r_count + {{(DECWIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign keep = (r_count == '0);

endmodule : acq_decim

`default_nettype wire

// File: rtl/acqbuf_ctrl.sv
// ============================================================================
//  Module  : acqbuf_ctrl
//  Brief   : Triggered ADC-stream capture into the BRAM-to-host buffer.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module acqbuf_ctrl
    import acqbuf_pkg::*;
#(
    parameter int unsigned ADDRWIDTH = c_addr_width,
    parameter int unsigned DATAWIDTH = c_data_width,
    parameter int unsigned DECWIDTH  = c_dec_width,
    parameter int unsigned MISSWIDTH = c_miss_width
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 abort,
    input  logic                 trig,
    input  logic [DECWIDTH-1:0]  decim,
    input  logic [ADDRWIDTH:0]   nsamp,
    input  logic [DATAWIDTH-1:0] adc_tdata,
    input  logic                 adc_tvalid,
    output logic                 adc_tready,
    output logic [ADDRWIDTH-1:0] bram_addr,
    output logic [DATAWIDTH-1:0] bram_din,
    output logic                 bram_we,
    output logic                 armed,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH:0]   wcount,
    output logic [MISSWIDTH-1:0] trig_missed
);

    localparam logic [ADDRWIDTH:0] c_full = {1'b1, {ADDRWIDTH{1'b0}}};
    localparam logic [ADDRWIDTH:0] c_one  = {{ADDRWIDTH{1'b0}}, 1'b1};

    acq_state_t r_state, w_state_nxt;

    logic [ADDRWIDTH:0]   r_nsamp;
    logic [ADDRWIDTH:0]   r_wcount;
    logic [ADDRWIDTH-1:0] r_bram_addr;
    logic [DATAWIDTH-1:0] r_bram_din;
    logic                 r_bram_we;
    logic [MISSWIDTH-1:0] r_trig_missed;

    logic                 w_arm_ok;
    logic                 w_start;
    logic                 w_accept;
    logic                 w_keep;
    logic                 w_write;
    logic                 w_last;
    logic [ADDRWIDTH:0]   w_wcount_inc;
    logic [ADDRWIDTH:0]   w_nsamp_clamped;

    assign w_arm_ok        = arm && !abort && (r_state == IDLE || r_state == DONE);
    assign w_nsamp_clamped = (nsamp > c_full) ? c_full : nsamp;
    assign w_start         = (r_state == ARMED) && trig && (r_nsamp != '0);
    // Abort suppresses acceptance so no write can emerge after the abort edge.
    assign w_accept        = adc_tvalid && !abort && ((r_state == CAPT) || w_start);
    assign w_write         = w_accept && w_keep;
    assign w_wcount_inc    = r_wcount + c_one;
    assign w_last          = w_write && (w_wcount_inc == r_nsamp);

    acq_decim #(
        .DECWIDTH (DECWIDTH)
    ) u_decim (
        .clk   (clk),
        .reset (reset),
        .clr   (abort),
        .ld    (w_arm_ok),
        .decim (decim),
        .en    (w_accept),
        .keep  (w_keep)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (arm) w_state_nxt = ARMED;
                ARMED: begin
                    if (trig) begin
                        if (r_nsamp == '0 || w_last) w_state_nxt = DONE;
                        else                         w_state_nxt = CAPT;
                    end
                end
                CAPT:    if (w_last) w_state_nxt = DONE;
                DONE:    if (arm) w_state_nxt = ARMED;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nsamp     <= '0;
            r_wcount    <= '0;
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_din  <= '0;
        end else begin
            r_bram_we <= w_write;
            if (w_arm_ok) begin
                r_nsamp  <= w_nsamp_clamped;
                r_wcount <= '0;
            end else if (w_write) begin
                r_bram_addr <= r_wcount[ADDRWIDTH-1:0];
                r_bram_din  <= adc_tdata;
                r_wcount    <= w_wcount_inc;
            end
        end
    end

    // Survives re-arm so the host can read how many triggers were lost overall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trig_missed <= '0;
        end else if (r_state == CAPT && trig && r_trig_missed != '1) begin
            r_trig_missed <= r_trig_missed + {{(MISSWIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign adc_tready  = !reset;
    assign bram_addr   = r_bram_addr;
    assign bram_din    = r_bram_din;
    assign bram_we     = r_bram_we;
    assign armed       = (r_state == ARMED);
    assign busy        = (r_state == CAPT);
    assign done        = (r_state == DONE);
    assign wcount      = r_wcount;
    assign trig_missed = r_trig_missed;

endmodule : acqbuf_ctrl

`default_nettype wire

// File: tb/tb_acqbuf_ctrl.sv
// ============================================================================
//  Module  : tb_acqbuf_ctrl
//  Brief   : Directed, table-driven bench for acqbuf_ctrl.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_acqbuf_ctrl;

    logic        clk;
    logic        reset;
    logic        arm;
    logic        abort;
    logic        trig;
    logic [7:0]  decim;
    logic [12:0] nsamp;
    logic [63:0] adc_tdata;
    logic        adc_tvalid;
    logic        adc_tready;
    logic [11:0] bram_addr;
    logic [63:0] bram_din;
    logic        bram_we;
    logic        armed;
    logic        busy;
    logic        done;
    logic [12:0] wcount;
    logic [7:0]  trig_missed;

    acqbuf_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .arm         (arm),
        .abort       (abort),
        .trig        (trig),
        .decim       (decim),
        .nsamp       (nsamp),
        .adc_tdata   (adc_tdata),
        .adc_tvalid  (adc_tvalid),
        .adc_tready  (adc_tready),
        .bram_addr   (bram_addr),
        .bram_din    (bram_din),
        .bram_we     (bram_we),
        .armed       (armed),
        .busy        (busy),
        .done        (done),
        .wcount      (wcount),
        .trig_missed (trig_missed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  decim;
        logic [12:0] nsamp;
        bit          gaps;
        logic [63:0] start;
        int          exp_nwr;
        logic [63:0] exp_last;
    } vec_t;

    typedef struct packed {
        logic [11:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         wq[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    bit          stream_en = 0;
    bit          gaps      = 0;
    int          k         = 0;
    logic [63:0] data_next = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of stream stimulus, cross one rising edge, log any write.
    task automatic cycle();
        if (stream_en) begin
            adc_tvalid = gaps ? ((k % 3) != 2) : 1'b1;
            adc_tdata  = data_next;
            if (adc_tvalid) data_next++;
            k++;
        end else begin
            adc_tvalid = 1'b0;
        end
        @(negedge clk);
        if (bram_we) wq.push_back('{addr: bram_addr, data: bram_din});
    endtask

    task automatic wait_writes(input string name, input int n, input int budget);
        int c = 0;
        while (wq.size() < n && c < budget) begin
            cycle();
            c++;
        end
        if (wq.size() < n) chk({name, "_timeout"}, 64'(wq.size()), 64'(n));
    endtask

    task automatic run_capture(input string tag, input vec_t v);
        int          bad = 0;
        logic [63:0] e;
        wq.delete();
        stream_en = 0;
        decim = v.decim; nsamp = v.nsamp; arm = 1'b1;
        cycle();
        arm = 1'b0;
        chk({tag, "_armed"}, 64'(armed), 64'd1);
        data_next = v.start; gaps = v.gaps; k = 0; stream_en = 1;
        trig = 1'b1;
        cycle();
        trig = 1'b0;
        wait_writes(tag, v.exp_nwr, 6000);
        chk({tag, "_done_at_last"}, 64'(done), 64'd1);
        if (v.exp_nwr > 0) chk({tag, "_we_with_done"}, 64'(bram_we), 64'd1);
        repeat (3) cycle();
        stream_en = 0;
        cycle();
        chk({tag, "_nwr"}, 64'(wq.size()), 64'(v.exp_nwr));
        chk({tag, "_wcount"}, 64'(wcount), 64'(v.exp_nwr));
        chk({tag, "_busy_off"}, 64'(busy), 64'd0);
        foreach (wq[i]) begin
            e = v.start + 64'(i) * (64'(v.decim) + 64'd1);
            if (wq[i].addr !== 12'(i) || wq[i].data !== e) bad++;
        end
        chk({tag, "_bad_writes"}, 64'(bad), 64'd0);
        if (v.exp_nwr > 0 && wq.size() > 0) begin
            chk({tag, "_last_data"}, wq[wq.size()-1].data, v.exp_last);
            chk({tag, "_last_addr"}, 64'(wq[wq.size()-1].addr), 64'(v.exp_nwr - 1));
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{decim: 8'd0, nsamp: 13'd4,    gaps: 0, start: 64'd100,  exp_nwr: 4,    exp_last: 64'd103};
        vecs[1] = '{decim: 8'd2, nsamp: 13'd3,    gaps: 1, start: 64'd0,    exp_nwr: 3,    exp_last: 64'd6};
        vecs[2] = '{decim: 8'd1, nsamp: 13'd5,    gaps: 0, start: 64'd50,   exp_nwr: 5,    exp_last: 64'd58};
        vecs[3] = '{decim: 8'd0, nsamp: 13'd1,    gaps: 1, start: 64'd7,    exp_nwr: 1,    exp_last: 64'd7};
        vecs[4] = '{decim: 8'd0, nsamp: 13'd0,    gaps: 0, start: 64'd20,   exp_nwr: 0,    exp_last: 64'd0};
        vecs[5] = '{decim: 8'd3, nsamp: 13'd4,    gaps: 1, start: 64'd10,   exp_nwr: 4,    exp_last: 64'd22};
        vecs[6] = '{decim: 8'd0, nsamp: 13'd4101, gaps: 0, start: 64'd1000, exp_nwr: 4096, exp_last: 64'd5095};

        reset = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0;
        decim = '0; nsamp = '0; adc_tdata = '0; adc_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tready", 64'(adc_tready), 64'd0);
        chk("rst_flags", {61'd0, armed, busy, done}, 64'd0);
        chk("rst_we", 64'(bram_we), 64'd0);
        chk("rst_wcount", 64'(wcount), 64'd0);
        chk("rst_missed", 64'(trig_missed), 64'd0);
        chk("rst_addr_din", 64'(bram_addr) | bram_din, 64'd0);
        reset = 1'b0;
        cycle();
        chk("tready_run", 64'(adc_tready), 64'd1);

        // arm together with abort in IDLE
        arm = 1'b1; abort = 1'b1; nsamp = 13'd2;
        cycle();
        arm = 1'b0; abort = 1'b0;
        chk("arm_abort_idle", {61'd0, armed, busy, done}, 64'd0);

        // trig in the arming cycle must not start a capture
        arm = 1'b1; trig = 1'b1;
        cycle();
        arm = 1'b0; trig = 1'b0;
        cycle();
        chk("trig_with_arm", {61'd0, armed, busy, done}, 64'b100);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_armed", {61'd0, armed, busy, done}, 64'd0);

        for (int i = 0; i < 7; i++) run_capture($sformatf("vec%0d", i), vecs[i]);

        // abort after five writes
        wq.delete();
        decim = 8'd0; nsamp = 13'd16; arm = 1'b1;
        cycle();
        arm = 1'b0;
        data_next = 64'd500; gaps = 0; k = 0; stream_en = 1; trig = 1'b1;
        cycle();
        trig = 1'b0;
        wait_writes("abort", 5, 50);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        repeat (4) cycle();
        stream_en = 0;
        chk("abort_nwr", 64'(wq.size()), 64'd5);
        chk("abort_wcount", 64'(wcount), 64'd5);
        chk("abort_flags", {61'd0, armed, busy, done}, 64'd0);
        run_capture("rearm", '{decim: 8'd0, nsamp: 13'd2, gaps: 0, start: 64'd200, exp_nwr: 2, exp_last: 64'd201});

        // arm during CAPT is ignored
        wq.delete();
        decim = 8'd0; nsamp = 13'd6; arm = 1'b1;
        cycle();
        arm = 1'b0;
        data_next = 64'd300; gaps = 0; k = 0; stream_en = 1; trig = 1'b1;
        cycle();
        trig = 1'b0;
        wait_writes("armcapt_a", 2, 50);
        decim = 8'd5; nsamp = 13'd1; arm = 1'b1;
        cycle();
        arm = 1'b0;
        chk("armcapt_busy", 64'(busy), 64'd1);
        wait_writes("armcapt_b", 6, 50);
        chk("armcapt_done", 64'(done), 64'd1);
        repeat (2) cycle();
        stream_en = 0;
        chk("armcapt_nwr", 64'(wq.size()), 64'd6);
        if (wq.size() == 6) chk("armcapt_last", wq[5].data, 64'd305);

        // missed triggers saturate
        chk("missed_pre", 64'(trig_missed), 64'd0);
        nsamp = 13'd10; decim = 8'd0; arm = 1'b1;
        cycle();
        arm = 1'b0; trig = 1'b1;
        cycle();
        chk("missed_capt", 64'(busy), 64'd1);
        repeat (10) cycle();
        chk("missed_10", 64'(trig_missed), 64'd10);
        repeat (290) cycle();
        trig = 1'b0;
        chk("missed_sat", 64'(trig_missed), 64'd255);
        chk("missed_wcount", 64'(wcount), 64'd0);
        abort = 1'b1;
        cycle();
        abort = 1'b0;

        // asynchronous reset between edges
        wq.delete();
        nsamp = 13'd16; arm = 1'b1;
        cycle();
        arm = 1'b0;
        data_next = 64'd0; gaps = 0; k = 0; stream_en = 1; trig = 1'b1;
        cycle();
        trig = 1'b0;
        wait_writes("arst", 3, 50);
        chk("arst_pre_we", 64'(bram_we), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_we", 64'(bram_we), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_wcount", 64'(wcount), 64'd0);
        chk("arst_tready", 64'(adc_tready), 64'd0);
        stream_en = 0;
        @(negedge clk);
        reset = 1'b0;
        cycle();
        chk("arst_idle", {61'd0, armed, busy, done}, 64'd0);
        chk("arst_tready_back", 64'(adc_tready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_acqbuf_ctrl

`default_nettype wire
